// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcode and funct encodings,
// the ALU operation set and the output-register state type.
package ex_stage_pkg;

  // Major opcodes, instruction[6:0]
  localparam logic [6:0] OPC_LUI         = 7'b0110111;
  localparam logic [6:0] OPC_IMM_REG_ALU = 7'b0010011;
  localparam logic [6:0] OPC_REG_REG_ALU = 7'b0110011;

  // funct3 field, instruction[14:12]
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 field, instruction[31:25]; only these two are legal for reg-reg ops
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } ex_state_e;

  // Map funct3 plus the alternate-op bit (SUB / SRA) to an ALU operation.
  // Callers clear alt where it is not meaningful (e.g. ADDI, where bit 30
  // is part of the immediate).
  function automatic alu_op_e decode_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Purely combinational integer ALU for the execute stage. All arithmetic
// wraps modulo 2^BITSIZE; shifts use the low log2(BITSIZE) bits of i_b.
module ex_stage_alu
  import ex_stage_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  alu_op_e            i_op,
  input  logic [BITSIZE-1:0] i_a,
  input  logic [BITSIZE-1:0] i_b,
  output logic [BITSIZE-1:0] o_result
);

  localparam int SHW = $clog2(BITSIZE);

  logic [SHW-1:0] w_shamt;
  logic           w_lt_signed;
  logic           w_lt_unsigned;

  assign w_shamt       = i_b[SHW-1:0];
  assign w_lt_signed   = $signed(i_a) < $signed(i_b);
  assign w_lt_unsigned = i_a < i_b;

  // Select the operation result; comparisons are zero-extended 0/1.
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = {{(BITSIZE-1){1'b0}}, w_lt_signed};
      ALU_SLTU: o_result = {{(BITSIZE-1){1'b0}}, w_lt_unsigned};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decodes the instruction into an ALU operation, computes the
// result and holds it in a single-entry output register that hands off to
// memory/writeback. Input ready is the downstream ready passed through when
// the register is full, so a full register can be drained and refilled in
// the same cycle.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               ID_EX_give_i,
  output logic               EX_ID_get_o,
  input  logic [31:0]        ID_EX_instruction_i,
  input  logic [BITSIZE-1:0] ID_EX_rs1_i,
  input  logic [BITSIZE-1:0] ID_EX_rs2_i,
  input  logic               MEM_EX_get_i,
  output logic               EX_MEM_give_o,
  output logic [31:0]        EX_MEM_instruction_o,
  output logic [BITSIZE-1:0] EX_MEM_result_o,
  output logic [4:0]         EX_MEM_rd_o,
  output logic               EX_MEM_wb_o,
  output logic               EX_MEM_illegal_o
);

  // Instruction fields
  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic [6:0]         w_funct7;
  logic [4:0]         w_rd;
  logic [BITSIZE-1:0] w_imm_i;
  logic [BITSIZE-1:0] w_imm_u;

  // Decode results
  alu_op_e            w_alu_op;
  logic [BITSIZE-1:0] w_alu_a;
  logic [BITSIZE-1:0] w_alu_b;
  logic [BITSIZE-1:0] w_alu_result;
  logic               w_wb;
  logic               w_illegal;

  // Handshake / FSM
  ex_state_e          r_state;
  ex_state_e          w_state_next;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_load;

  // Output register
  logic [31:0]        r_instr;
  logic [BITSIZE-1:0] r_result;
  logic [4:0]         r_rd;
  logic               r_wb;
  logic               r_illegal;

  assign w_opcode = ID_EX_instruction_i[6:0];
  assign w_funct3 = ID_EX_instruction_i[14:12];
  assign w_funct7 = ID_EX_instruction_i[31:25];
  assign w_rd     = ID_EX_instruction_i[11:7];

  // I-type immediate is sign-extended; U-type fills the upper 20 bits.
  assign w_imm_i = BITSIZE'($signed(ID_EX_instruction_i[31:20]));
  assign w_imm_u = BITSIZE'($signed({ID_EX_instruction_i[31:12], 12'h000}));

  // Decode opcode/funct fields into ALU operands, operation and flags.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_alu_op  = ALU_ADD;
    w_alu_a   = ID_EX_rs1_i;
    w_alu_b   = ID_EX_rs2_i;
    w_wb      = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        // LUI is an add of the U-immediate to zero; operands are ignored.
        w_alu_a = '0;
        w_alu_b = w_imm_u;
        w_wb    = 1'b1;
      end
      OPC_IMM_REG_ALU: begin
        // Shamt sits in imm[4:0]; bit 30 only distinguishes SRAI from SRLI.
        w_alu_b  = w_imm_i;
        w_alu_op = decode_op(w_funct3,
                             (w_funct3 == F3_SRL_SRA) && ID_EX_instruction_i[30]);
        w_wb     = 1'b1;
      end
      OPC_REG_REG_ALU: begin
        if ((w_funct7 == F7_BASE) || (w_funct7 == F7_ALT)) begin
          w_alu_op = decode_op(w_funct3, ID_EX_instruction_i[30]);
          w_wb     = 1'b1;
        end else begin
          w_alu_a   = '0;
          w_alu_b   = '0;
          w_illegal = 1'b1;
        end
      end
      default: begin
        // Unsupported opcode: zero result, no writeback, flagged downstream.
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_illegal = 1'b1;
      end
    endcase
    // Writes to x0 are suppressed but the result is still computed.
    if (w_rd == 5'd0) begin
      w_wb = 1'b0;
    end
  end

  ex_stage_alu #(
    .BITSIZE (BITSIZE)
  ) u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result)
  );

  assign EX_MEM_give_o = (r_state == ST_FULL);
  assign EX_ID_get_o   = (r_state == ST_EMPTY) || MEM_EX_get_i;
  assign w_in_xfer     = ID_EX_give_i && EX_ID_get_o;
  assign w_out_xfer    = EX_MEM_give_o && MEM_EX_get_i;

  // Next-state and load-enable for the single-entry output register.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_load       = 1'b1;
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          if (w_in_xfer) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // State register; reset discards any unconsumed result.
  always_ff @(posedge clk or negedge resetn_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of process evaluation order.
    if (!resetn_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output register payload; holds bit-identical while not loaded.
  always_ff @(posedge clk or negedge resetn_i) begin
    // NOTE: the payload is reset too, since its values are visible on the
    // outputs and must read zero during reset, not just be flagged invalid.
    if (!resetn_i) begin
      r_instr   <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_wb      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_instr   <= ID_EX_instruction_i;
      r_result  <= w_alu_result;
      r_rd      <= w_rd;
      r_wb      <= w_wb;
      r_illegal <= w_illegal;
    end
  end

  assign EX_MEM_instruction_o = r_instr;
  assign EX_MEM_result_o      = r_result;
  assign EX_MEM_rd_o          = r_rd;
  assign EX_MEM_wb_o          = r_wb;
  assign EX_MEM_illegal_o     = r_illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: accepted inputs push a reference-model
// result; a monitor pops and compares on every output transfer and checks
// handshake levels and hold-stability every cycle.
module tb_ex_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic        ID_EX_give_i;
  logic        EX_ID_get_o;
  logic [31:0] ID_EX_instruction_i;
  logic [31:0] ID_EX_rs1_i;
  logic [31:0] ID_EX_rs2_i;
  logic        MEM_EX_get_i;
  logic        EX_MEM_give_o;
  logic [31:0] EX_MEM_instruction_o;
  logic [31:0] EX_MEM_result_o;
  logic [4:0]  EX_MEM_rd_o;
  logic        EX_MEM_wb_o;
  logic        EX_MEM_illegal_o;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;
  int   checks = 0;
  int   errors = 0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  ex_stage #(.BITSIZE(32)) dut (
    .clk                  (clk),
    .resetn_i             (resetn_i),
    .ID_EX_give_i         (ID_EX_give_i),
    .EX_ID_get_o          (EX_ID_get_o),
    .ID_EX_instruction_i  (ID_EX_instruction_i),
    .ID_EX_rs1_i          (ID_EX_rs1_i),
    .ID_EX_rs2_i          (ID_EX_rs2_i),
    .MEM_EX_get_i         (MEM_EX_get_i),
    .EX_MEM_give_o        (EX_MEM_give_o),
    .EX_MEM_instruction_o (EX_MEM_instruction_o),
    .EX_MEM_result_o      (EX_MEM_result_o),
    .EX_MEM_rd_o          (EX_MEM_rd_o),
    .EX_MEM_wb_o          (EX_MEM_wb_o),
    .EX_MEM_illegal_o     (EX_MEM_illegal_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the arithmetic rules, not the RTL structure.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh);
    logic [31:0] fill;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        fill = (alt && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        return (a >> sh) | fill;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] imm;
    e.instr   = ins;
    e.rd      = ins[11:7];
    e.result  = 32'h0;
    e.wb      = 1'b0;
    e.illegal = 1'b0;
    imm = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      7'h37: begin
        e.result = {ins[31:12], 12'h000};
        e.wb     = 1'b1;
      end
      7'h13: begin
        e.result = ref_op(ins[14:12], (ins[14:12] == 3'd5) && ins[30], a, imm, ins[24:20]);
        e.wb     = 1'b1;
      end
      7'h33: begin
        if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) begin
          e.result = ref_op(ins[14:12], ins[30], a, b, b[4:0]);
          e.wb     = 1'b1;
        end else begin
          e.illegal = 1'b1;
        end
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.rd == 5'd0) e.wb = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    case (k)
      0: w[6:0] = 7'h37;
      1, 2, 3: begin
        w[6:0] = 7'h13;
        if (w[14:12] == 3'd1) w[31:25] = 7'h00;
        else if (w[14:12] == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
      end
      4, 5, 6, 7: begin
        w[6:0] = 7'h33;
        if (w[14:12] == 3'd0 || w[14:12] == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
        else w[31:25] = 7'h00;
      end
      8: begin
        w[6:0] = 7'h33;
        w[25]  = 1'b1;
      end
      default: begin
        w[6:0] = 7'($urandom);
        if (w[6:0] == 7'h37 || w[6:0] == 7'h13 || w[6:0] == 7'h33) w[6:0] = 7'h7F;
      end
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Push the reference result for every accepted input.
  always @(negedge clk) begin
    if (resetn_i === 1'b1 && ID_EX_give_i && EX_ID_get_o) begin
      push_e = model(ID_EX_instruction_i, ID_EX_rs1_i, ID_EX_rs2_i);
      #1 sb.push_back(push_e);
    end
  end

  // Monitor: handshake levels, held-entry contents, pop on output transfer.
  always @(negedge clk) begin
    if (resetn_i === 1'b1) begin
      check("give_level", 32'(EX_MEM_give_o), 32'(sb.size() != 0));
      check("get_level", 32'(EX_ID_get_o), 32'((sb.size() == 0) || MEM_EX_get_i));
      if (EX_MEM_give_o && sb.size() != 0) begin
        mon_e = sb[0];
        check("out_instr", EX_MEM_instruction_o, mon_e.instr);
        check("out_result", EX_MEM_result_o, mon_e.result);
        check("out_rd", 32'(EX_MEM_rd_o), 32'(mon_e.rd));
        check("out_wb", 32'(EX_MEM_wb_o), 32'(mon_e.wb));
        check("out_illegal", 32'(EX_MEM_illegal_o), 32'(mon_e.illegal));
        if (MEM_EX_get_i) void'(sb.pop_front());
      end
    end
  end

  // Drive one instruction and hold it until accepted (bounded).
  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int   n = 0;
    logic acc;
    ID_EX_give_i        = 1'b1;
    ID_EX_instruction_i = ins;
    ID_EX_rs1_i         = a;
    ID_EX_rs2_i         = b;
    do begin
      @(negedge clk);
      acc = EX_ID_get_o;
      @(posedge clk);
      #1;
      if (rand_ready) MEM_EX_get_i = ($urandom_range(0, 3) != 0);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted instr=%h", ins);
    end
    ID_EX_give_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    MEM_EX_get_i = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 entries left", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_give"}, 32'(EX_MEM_give_o), 32'd0);
    check({tag, "_instr"}, EX_MEM_instruction_o, 32'h0);
    check({tag, "_result"}, EX_MEM_result_o, 32'h0);
    check({tag, "_rd"}, 32'(EX_MEM_rd_o), 32'd0);
    check({tag, "_wb"}, 32'(EX_MEM_wb_o), 32'd0);
    check({tag, "_illegal"}, 32'(EX_MEM_illegal_o), 32'd0);
    check({tag, "_get"}, 32'(EX_ID_get_o), 32'd1);
  endtask

  initial begin
    logic [31:0] bp_instr;
    resetn_i            = 1'b0;
    ID_EX_give_i        = 1'b0;
    ID_EX_instruction_i = 32'h0;
    ID_EX_rs1_i         = 32'h0;
    ID_EX_rs2_i         = 32'h0;
    MEM_EX_get_i        = 1'b0;
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #3 resetn_i = 1'b1;
    MEM_EX_get_i = 1'b1;

    // Directed cases with literal expectations, downstream always ready.
    send(32'hFFD1_0093, 32'd5, 32'd0);
    check("addi_result", EX_MEM_result_o, 32'h0000_0002);
    check("addi_rd", 32'(EX_MEM_rd_o), 32'd1);
    check("addi_wb", 32'(EX_MEM_wb_o), 32'd1);
    check("addi_give", 32'(EX_MEM_give_o), 32'd1);
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd3, 32'd5);
    check("sub_result", EX_MEM_result_o, 32'hFFFF_FFFE);
    send(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'h8000_0000, 32'd4);
    check("sra_result", EX_MEM_result_o, 32'hF800_0000);
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3), 32'd1, 32'hFFFF_FFFF);
    check("sltu_result", EX_MEM_result_o, 32'd1);
    send(32'h1234_52B7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("lui_result", EX_MEM_result_o, 32'h1234_5000);
    check("lui_rd", 32'(EX_MEM_rd_o), 32'd5);
    send(32'h0000_007F, 32'h1234_5678, 32'h9ABC_DEF0);
    check("bad_opc_illegal", 32'(EX_MEM_illegal_o), 32'd1);
    check("bad_opc_wb", 32'(EX_MEM_wb_o), 32'd0);
    check("bad_opc_result", EX_MEM_result_o, 32'h0);
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd1, 32'd2);
    check("add_x0_illegal", 32'(EX_MEM_illegal_o), 32'd0);
    check("add_x0_wb", 32'(EX_MEM_wb_o), 32'd0);
    check("add_x0_result", EX_MEM_result_o, 32'd3);
    drain();

    // Backpressure: three stalled cycles with decode giving, then release.
    bp_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4);
    send(bp_instr, 32'd10, 32'd20);
    MEM_EX_get_i = 1'b0;
    fork
      send(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd6), 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_get_low", 32'(EX_ID_get_o), 32'd0);
          check("bp_hold_result", EX_MEM_result_o, 32'd30);
          check("bp_hold_instr", EX_MEM_instruction_o, bp_instr);
          check("bp_hold_give", 32'(EX_MEM_give_o), 32'd1);
        end
        @(posedge clk);
        #1 MEM_EX_get_i = 1'b1;
      end
    join
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd7), 32'h0000_0001, 32'd31);
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd8), 32'hFFFF_FFFF, 32'd1);
    drain();

    // Randomized traffic with random downstream backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1 MEM_EX_get_i = ($urandom_range(0, 3) != 0);
      end
      send(rand_instr(), rand_val(), rand_val());
    end
    rand_ready = 1'b0;
    drain();

    // Asynchronous reset mid-cycle while a result is held.
    MEM_EX_get_i = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'h1111_0000, 32'h0000_2222);
    #2 resetn_i = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    @(posedge clk);
    #3 resetn_i = 1'b1;
    MEM_EX_get_i = 1'b1;
    send(32'hFFD1_0093, 32'd5, 32'd0);
    check("post_rst_result", EX_MEM_result_o, 32'h0000_0002);
    check("post_rst_give", 32'(EX_MEM_give_o), 32'd1);
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
